// File: rtl/instr_fetch.sv
// instr_fetch: program counter, single-outstanding instruction memory reads,
// and a small FIFO that feeds the decoder over valid/ready. A one-cycle
// redirect flushes the FIFO and restarts fetch at a new word address.
// Optional feature macro: IFETCH_PC_OUT_EN stores the PC with every word and
// exposes it on instr_pc.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction
`ifdef IFETCH_PC_OUT_EN
  ,
  output logic [31:0] instr_pc
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] RESET_PC_W = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FLUSH
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_pc;
  logic [31:0]   r_kill_addr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_word_mem [DEPTH];
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_target;

  assign w_redirect_target = redirect_pc & ~32'h3;

  // Request outputs come from registered state only, so they never glitch
  // with mem_ack or redirect.
  assign mem_req  = (r_state == S_WAIT) || (r_state == S_FLUSH);
  assign mem_addr = (r_state == S_FLUSH) ? r_kill_addr : r_pc;

  assign instr_valid = (r_count != '0);
  assign instruction = r_word_mem[r_rd_ptr];

  // A redirect kills both the returning word and any decoder pop this cycle.
  assign w_push = (r_state == S_WAIT) && mem_ack && !redirect;
  assign w_pop  = instr_valid && instr_ready && !redirect;

  // Occupancy after this edge; flush overrides push/pop.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_count_next = r_count;
    if (redirect) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Next-state logic. Issue decisions look at post-edge occupancy so a pop
  // from a full FIFO re-issues the request in the very next cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_count_next < FULL) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          // Unacked request is still in flight: wait it out in FLUSH.
          w_state_next = mem_ack ? S_WAIT : S_FLUSH;
        end else if (mem_ack) begin
          w_state_next = (w_count_next < FULL) ? S_WAIT : S_IDLE;
        end
      end
      S_FLUSH: begin
        // A further redirect only retargets pc; the killed read stays pending.
        if (!redirect && mem_ack) w_state_next = S_WAIT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Program counter and the address of a killed in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC_W;
      r_kill_addr <= RESET_PC_W;
    end else begin
      if (r_state == S_WAIT && redirect && !mem_ack) r_kill_addr <= r_pc;
      if (redirect)    r_pc <= w_redirect_target;
      else if (w_push) r_pc <= r_pc + 32'd4;
    end
  end

  // FIFO pointers, occupancy and word storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      // NOTE: storage is reset so instruction reads 0 out of reset; drop this
      // loop if a defined head word is not needed, to let tools use RAM.
      for (int i = 0; i < int'(DEPTH); i++) r_word_mem[i] <= '0;
    end else begin
      r_count <= w_count_next;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_word_mem[r_wr_ptr] <= mem_rdata;
          r_wr_ptr             <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

`ifdef IFETCH_PC_OUT_EN
  logic [31:0] r_pc_mem [DEPTH];

  assign instr_pc = r_pc_mem[r_rd_ptr];

  // PC side of each FIFO entry, written alongside the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_pc_mem[i] <= '0;
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr] <= r_pc;
    end
  end
`endif

endmodule
